// File: rtl/mips_cache_pkg.sv
// Shared definitions for the MIPS instruction cache.
// Contents:
//   ic_state_e     refill FSM states (IC_IDLE, IC_REFILL)
//   MEM_ADDR_RST   reset value of the memory beat address register
//   ic_off_bits    word-offset field width for a given line size
//   ic_idx_bits    line-index field width for a given line count
//   ic_tag_bits    tag width left over from a 32-bit byte address
package mips_cache_pkg;

  typedef enum logic [0:0] {
    IC_IDLE   = 1'b0,
    IC_REFILL = 1'b1
  } ic_state_e;

  localparam logic [31:0] MEM_ADDR_RST = 32'h0000_0000;

  function automatic int unsigned ic_off_bits(input int unsigned words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int unsigned ic_idx_bits(input int unsigned lines);
    return $clog2(lines);
  endfunction

  // The two lowest address bits select a byte within a word and are not stored.
  function automatic int unsigned ic_tag_bits(input int unsigned lines,
                                              input int unsigned words_per_line);
    return 32 - 2 - ic_off_bits(words_per_line) - ic_idx_bits(lines);
  endfunction

endpackage

// File: rtl/icache_data_array.sv
// Tag, valid and data storage for the direct-mapped instruction cache.
// Ports:
//   clk, reset         clock; synchronous active-high reset (clears valid bits only)
//   wr_en              write wr_data into data[wr_idx][wr_word]
//   set_valid          write wr_tag into tag[wr_idx] and set valid[wr_idx]
//   inv_all            clear every valid bit (wins over set_valid)
//   rd_idx, rd_word    combinational read address
//   rd_valid, rd_tag,
//   rd_data            combinational read data
module icache_data_array
  import mips_cache_pkg::*;
#(
  parameter int unsigned LINES          = 16,
  parameter int unsigned WORDS_PER_LINE = 4,
  localparam int unsigned OFF   = ic_off_bits(WORDS_PER_LINE),
  localparam int unsigned IDX   = ic_idx_bits(LINES),
  localparam int unsigned TAG_W = ic_tag_bits(LINES, WORDS_PER_LINE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX-1:0]   wr_idx,
  input  logic [OFF-1:0]   wr_word,
  input  logic [31:0]      wr_data,
  input  logic             set_valid,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             inv_all,
  input  logic [IDX-1:0]   rd_idx,
  input  logic [OFF-1:0]   rd_word,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][WORDS_PER_LINE];

  // A fill that completes together with an invalidate must not survive it.
  always_ff @(posedge clk) begin
    if (reset || inv_all) begin
      valid_q <= '0;
    end else if (set_valid) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_idx][wr_word] <= wr_data;
    end
    if (set_valid) begin
      tag_q[wr_idx] <= wr_tag;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx][rd_word];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with in-order line refill.
// Optional feature macro: ICACHE_STATS_EN adds hit_count / miss_count.
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   pc              fetch byte address (pc[1:0] ignored)
//   instr           instruction word, valid when stall=0
//   stall           core must hold PC and IF/ID
//   inv             one-cycle pulse invalidating all lines
//   mem_req         refill beat request, held until mem_ack
//   mem_addr        word-aligned byte address of the requested beat
//   mem_rdata       beat data, sampled with mem_ack
//   mem_ack         one-cycle beat completion
//   hit_count,
//   miss_count      statistics (ICACHE_STATS_EN only)
module icache
  import mips_cache_pkg::*;
#(
  parameter int unsigned LINES          = 16,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  output logic        stall,
  input  logic        inv,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned OFF    = ic_off_bits(WORDS_PER_LINE);
  localparam int unsigned IDX    = ic_idx_bits(LINES);
  localparam int unsigned TAG_W  = ic_tag_bits(LINES, WORDS_PER_LINE);
  localparam int unsigned LINE_W = 30 - OFF;
  localparam logic [OFF-1:0] BEAT_LAST = OFF'(WORDS_PER_LINE - 1);
  localparam logic [OFF-1:0] BEAT_ONE  = OFF'(1);

  ic_state_e         state_q;
  logic [OFF-1:0]    beat_q;
  logic [OFF-1:0]    beat_nxt;
  logic [LINE_W-1:0] miss_line_q;
  logic              inv_pend_q;
  logic              mem_req_q;
  logic [31:0]       mem_addr_q;

  logic [LINE_W-1:0] pc_line;
  logic [IDX-1:0]    pc_idx;
  logic [OFF-1:0]    pc_word;
  logic [TAG_W-1:0]  pc_tag;
  logic              unused_pc_bits;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_data;
  logic              hit;
  logic              fill;
  logic              fill_last;
  logic              inv_all;

  assign pc_line        = pc[31:2+OFF];
  assign pc_idx         = pc[2+OFF+IDX-1:2+OFF];
  assign pc_word        = pc[2+OFF-1:2];
  assign pc_tag         = pc[31:2+OFF+IDX];
  assign unused_pc_bits = ^pc[1:0];

  assign beat_nxt  = beat_q + BEAT_ONE;
  assign hit       = rd_valid && (rd_tag == pc_tag);
  assign fill      = !reset && (state_q == IC_REFILL) && mem_ack;
  assign fill_last = fill && (beat_q == BEAT_LAST);
  // An inv arriving on the last-beat cycle counts as pending for that fill.
  assign inv_all   = !reset && (((state_q == IC_IDLE) && inv) ||
                                (fill_last && (inv_pend_q || inv)));

  assign stall    = !reset && ((state_q == IC_REFILL) || !hit);
  assign instr    = rd_data;
  // Gated so the request is already low while reset is held.
  assign mem_req  = mem_req_q && !reset;
  assign mem_addr = mem_addr_q;

  icache_data_array #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_data_array (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (fill),
    .wr_idx    (miss_line_q[IDX-1:0]),
    .wr_word   (beat_q),
    .wr_data   (mem_rdata),
    .set_valid (fill_last),
    .wr_tag    (miss_line_q[LINE_W-1:IDX]),
    .inv_all   (inv_all),
    .rd_idx    (pc_idx),
    .rd_word   (pc_word),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IC_IDLE;
      beat_q     <= '0;
      inv_pend_q <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= MEM_ADDR_RST;
    end else begin
      unique case (state_q)
        IC_IDLE: begin
          if (!hit) begin
            state_q     <= IC_REFILL;
            miss_line_q <= pc_line;
            beat_q      <= '0;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= {pc_line, {OFF{1'b0}}, 2'b00};
          end
        end
        IC_REFILL: begin
          if (inv) begin
            inv_pend_q <= 1'b1;
          end
          if (mem_ack) begin
            if (beat_q == BEAT_LAST) begin
              state_q    <= IC_IDLE;
              mem_req_q  <= 1'b0;
              inv_pend_q <= 1'b0;
            end else begin
              beat_q     <= beat_nxt;
              mem_addr_q <= {miss_line_q, beat_nxt, 2'b00};
            end
          end
        end
        default: state_q <= IC_IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_q == IC_IDLE) begin
      if (hit) begin
        hit_count <= hit_count + 32'd1;
      end else begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a cache-contents model (valid + line address per
// index, memory word = address ^ 0xDEAD0000) checked every cycle, plus
// hand-computed stall counts and beat address sequences.
module tb_icache;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        stall;
  logic        inv;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache #(
    .LINES          (16),
    .WORDS_PER_LINE (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .instr      (instr),
    .stall      (stall),
    .inv        (inv),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 1;
  logic [31:0] ack_q[$];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: ack each beat after lat cycles of mem_req.
  initial begin
    int wcnt;
    wcnt      = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_req) begin
        if (wcnt == lat - 1) begin
          mem_ack   = 1'b1;
          mem_rdata = memfn(mem_addr);
          wcnt      = 0;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end
    end
  end

  // Model of what the cache holds and whether a refill is in progress.
  bit          m_valid [16];
  logic [27:0] m_line  [16];
  bit          m_refill = 1'b0;
  logic [27:0] m_miss_line = '0;
  logic [1:0]  m_beat = '0;
  bit          m_pend = 1'b0;
  int          m_hits = 0;
  int          m_misses = 0;

  task automatic model_step();
    logic [3:0] idx;
    bit         m_hit;
    bit         exp_stall;
    idx       = pc[7:4];
    m_hit     = m_valid[idx] && (m_line[idx] == pc[31:4]);
    exp_stall = !reset && (m_refill || !m_hit);
    chk("stall", {31'd0, stall}, {31'd0, exp_stall});
    chk("mem_req", {31'd0, mem_req}, {31'd0, !reset && m_refill});
    if (!exp_stall && !reset) chk("instr", instr, memfn(pc));
    if (!reset && m_refill) chk("mem_addr", mem_addr, {m_miss_line, m_beat, 2'b00});
`ifdef ICACHE_STATS_EN
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_misses);
`endif
    if (!reset && mem_req && mem_ack) ack_q.push_back(mem_addr);
    // Advance to the state after the coming edge.
    if (reset) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      m_refill = 1'b0;
      m_pend   = 1'b0;
      m_hits   = 0;
      m_misses = 0;
    end else if (!m_refill) begin
      if (m_hit) begin
        m_hits++;
      end else begin
        m_refill    = 1'b1;
        m_miss_line = pc[31:4];
        m_beat      = 2'd0;
        m_misses++;
      end
      if (inv) foreach (m_valid[i]) m_valid[i] = 1'b0;
    end else begin
      if (inv) m_pend = 1'b1;
      if (mem_ack) begin
        if (m_beat == 2'd3) begin
          m_valid[m_miss_line[3:0]] = 1'b1;
          m_line[m_miss_line[3:0]]  = m_miss_line;
          m_refill = 1'b0;
          if (m_pend) foreach (m_valid[i]) m_valid[i] = 1'b0;
          m_pend = 1'b0;
        end else begin
          m_beat = m_beat + 2'd1;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  task automatic set_pc(input logic [31:0] a);
    @(posedge clk);
    #1;
    pc = a;
  endtask

  task automatic run_until_hit(output int n);
    bit done;
    n    = 0;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
      else n++;
    end
    if (!done) chk("unstall_timeout", 32'd1, 32'd0);
  endtask

  // Expect nlines consecutive 4-beat line fetches, first at a0 then at a1.
  task automatic chk_acks(input string name, input logic [31:0] a0, input logic [31:0] a1,
                          input int nlines);
    logic [31:0] base;
    chk({name, "_count"}, ack_q.size(), nlines * 4);
    for (int i = 0; i < nlines * 4 && i < ack_q.size(); i++) begin
      base = (i < 4) ? a0 : a1;
      chk({name, "_addr"}, ack_q[i], base + 32'(4 * (i % 4)));
    end
  endtask

  initial begin
    int n;
    int n2;
    reset = 1'b1;
    pc    = 32'h40;
    inv   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);

    // Cold miss at 0x40, zero-wait memory.
    @(posedge clk);
    #1;
    reset = 1'b0;
    ack_q.delete();
    run_until_hit(n);
    chk("cold_stall_cycles", n, 5);
    chk_acks("cold", 32'h40, 32'h40, 1);
    chk("cold_instr", instr, 32'hDEAD_0040);

    // Sweep the filled line.
    for (int k = 0; k < 4; k++) begin
      set_pc(32'h40 + 32'(4 * k));
      @(negedge clk);
      chk("sweep_stall", {31'd0, stall}, 32'd0);
      chk("sweep_mem_req", {31'd0, mem_req}, 32'd0);
    end
    chk("sweep_instr_4c", instr, 32'hDEAD_004C);

    // Conflict on index 4.
    set_pc(32'h440);
    run_until_hit(n);
    chk("conflict_stall_cycles", n, 5);
    chk("conflict_instr", instr, 32'hDEAD_0440);
    set_pc(32'h40);
    ack_q.delete();
    run_until_hit(n);
    chk("reload_stall_cycles", n, 5);
    chk_acks("reload", 32'h40, 32'h40, 1);
    chk("model_misses", m_misses, 3);

    // inv during beat 2 of a refill for 0x80.
    set_pc(32'h80);
    ack_q.delete();
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (stall) n++;
    end
    @(posedge clk);
    #1;
    inv = 1'b1;
    @(negedge clk);
    if (stall) n++;
    @(posedge clk);
    #1;
    inv = 1'b0;
    run_until_hit(n2);
    chk("inv_stall_cycles", n + n2, 10);
    chk_acks("inv", 32'h80, 32'h80, 2);

    // Reset during beat 1 of a refill for 0xC0.
    set_pc(32'hC0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    ack_q.delete();
    @(negedge clk);
    chk("in_reset_mem_req", {31'd0, mem_req}, 32'd0);
    chk("in_reset_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_mem_req", {31'd0, mem_req}, 32'd0);
    chk("post_reset_stall", {31'd0, stall}, 32'd1);
    run_until_hit(n);
    chk("post_reset_stall_cycles", n, 4);
    chk_acks("restart", 32'hC0, 32'hC0, 1);

    // 3-cycle beats, pc redirected to 0x100 mid-refill of 0x140.
    lat = 3;
    set_pc(32'h140);
    ack_q.delete();
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (stall) n++;
    end
    set_pc(32'h100);
    run_until_hit(n2);
    chk("redirect_stall_cycles", n + n2, 26);
    chk_acks("redirect", 32'h140, 32'h100, 2);
    chk("redirect_instr", instr, 32'hDEAD_0100);

    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
